// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between an instruction-fetch
// requester and a data requester. One transaction is in flight at a time;
// ties are broken by alternating with the requester served last. RAM
// control outputs are registered and only active for the single ACCESS
// cycle. Read data is captured after RAM_LAT cycles.
module ram_arbiter #(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        stall_req,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [1:0] LAT_INIT = 2'(RAM_LAT);

  logic [1:0] state_r;
  logic [1:0] cnt_r;
  logic       owner_data_r;  // 1: data requester owns the current transaction
  logic       last_data_r;   // 1: data requester was granted last
  logic       write_r;       // current transaction is a write
  logic       grant_data_s;
  logic       any_req_s;

  // Requesters stall the pipeline until their ack arrives.
  assign stall_req = (d_req & ~d_ack) | (if_req & ~if_ack);

  // Owner selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_data_s = 1'b0;
    any_req_s    = if_req | d_req;
    if (d_req && if_req) begin
      grant_data_s = ~last_data_r;
    end else begin
      grant_data_s = d_req;
    end
  end

  // Transaction FSM with registered RAM controls, acks and read-data capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      owner_data_r <= 1'b0;
      last_data_r  <= 1'b0;
      write_r      <= 1'b0;
      ram_ce       <= 1'b0;
      ram_we       <= 1'b0;
      ram_sel      <= 4'd0;
      ram_addr     <= 32'd0;
      ram_wdata    <= 32'd0;
      if_rdata     <= 32'd0;
      d_rdata      <= 32'd0;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_data_r <= grant_data_s;
            last_data_r  <= grant_data_s;
            ram_ce       <= 1'b1;
            if (grant_data_s) begin
              ram_we    <= d_we;
              ram_sel   <= d_sel;
              ram_addr  <= d_addr;
              ram_wdata <= d_wdata;
              write_r   <= d_we;
            end else begin
              ram_we    <= 1'b0;
              ram_sel   <= 4'b1111;
              ram_addr  <= if_addr;
              ram_wdata <= 32'd0;
              write_r   <= 1'b0;
            end
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          ram_ce  <= 1'b0;
          ram_we  <= 1'b0;
          ram_sel <= 4'd0;
          if (write_r) begin
            if (owner_data_r) begin
              d_ack <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
            state_r <= RESP;
          end else begin
            cnt_r   <= LAT_INIT;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 2'd1;
          if (cnt_r == 2'd1) begin
            if (owner_data_r) begin
              d_rdata <= ram_rdata;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= ram_rdata;
              if_ack   <= 1'b1;
            end
            state_r <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: two arbiters share the request inputs; u_dut1 (RAM_LAT=1)
// runs directed and random traffic while u_dut3 (RAM_LAT=3) is held in reset,
// then u_dut3 runs the abort-in-WAIT scenario while u_dut1 is held in reset.
module tb_ram_arbiter;

  logic        clk;
  logic        reset_n1, reset_n3;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_sel;

  logic [31:0] if_rdata1, d_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
  logic        if_ack1, d_ack1, stall1, ram_ce1, ram_we1;
  logic [3:0]  ram_sel1;
  logic [31:0] if_rdata3, d_rdata3, ram_addr3, ram_wdata3, ram_rdata3;
  logic        if_ack3, d_ack3, stall3, ram_ce3, ram_we3;
  logic [3:0]  ram_sel3;

  logic [31:0] rp1, rp3a, rp3b, rp3c;

  int          n_tests, n_fail;
  bit          last_d, d_pend, i_pend;
  logic [31:0] exp_if_rd, exp_d_rd;

  ram_arbiter #(.RAM_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n1),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_ack(d_ack1), .stall_req(stall1),
    .ram_ce(ram_ce1), .ram_we(ram_we1), .ram_sel(ram_sel1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  ram_arbiter #(.RAM_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n3),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_ack(if_ack3),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata3), .d_ack(d_ack3), .stall_req(stall3),
    .ram_ce(ram_ce3), .ram_we(ram_we3), .ram_sel(ram_sel3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents as a pure function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h3C01_1234;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // RAM model: valid data RAM_LAT cycles after a read ce, random junk otherwise.
  always @(posedge clk) begin
    rp1  <= (ram_ce1 && !ram_we1) ? mem_f(ram_addr1) : $urandom;
    rp3a <= (ram_ce3 && !ram_we3) ? mem_f(ram_addr3) : $urandom;
    rp3b <= rp3a;
    rp3c <= rp3b;
  end
  assign ram_rdata1 = rp1;
  assign ram_rdata3 = rp3c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_inputs();
    if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
    d_sel = 4'($urandom); if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
  endtask

  task automatic new_d();
    d_req = 1'b1; d_pend = 1'b1; d_we = 1'($urandom_range(1, 0));
    d_sel = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
  endtask

  task automatic new_i();
    if_req = 1'b1; i_pend = 1'b1; if_addr = $urandom;
  endtask

  // Called in an IDLE cycle right after the inputs were set.
  task automatic idle_check();
    #1;
    chk("idle_ram_ce", 32'(ram_ce1), 32'd0);
    chk("idle_d_ack", 32'(d_ack1), 32'd0);
    chk("idle_if_ack", 32'(if_ack1), 32'd0);
    chk("idle_stall", 32'(stall1), 32'(d_req | if_req));
  endtask

  // Reference for one u_dut1 transaction starting from the current IDLE cycle.
  task automatic txn1();
    bit          own_d, ack_now;
    int          lat;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr, e_wdata;
    own_d   = (d_req && if_req) ? !last_d : d_req;
    last_d  = own_d;
    e_we    = own_d ? d_we : 1'b0;
    e_sel   = own_d ? d_sel : 4'hF;
    e_addr  = own_d ? d_addr : if_addr;
    e_wdata = own_d ? d_wdata : 32'h0;
    lat     = e_we ? 2 : 3;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      ack_now = (c == lat);
      if (ack_now && !e_we) begin
        if (own_d) exp_d_rd = mem_f(e_addr);
        else exp_if_rd = mem_f(e_addr);
      end
      chk("ram_ce", 32'(ram_ce1), 32'(c == 1));
      chk("ram_we", 32'(ram_we1), 32'((c == 1) && e_we));
      chk("ram_sel", 32'(ram_sel1), (c == 1) ? 32'(e_sel) : 32'd0);
      chk("ram_addr", ram_addr1, e_addr);
      chk("ram_wdata", ram_wdata1, e_wdata);
      chk("d_ack", 32'(d_ack1), 32'(ack_now && own_d));
      chk("if_ack", 32'(if_ack1), 32'(ack_now && !own_d));
      chk("d_rdata", d_rdata1, exp_d_rd);
      chk("if_rdata", if_rdata1, exp_if_rd);
      chk("stall", 32'(stall1),
          32'((d_req && !(ack_now && own_d)) || (if_req && !(ack_now && !own_d))));
    end
    if (own_d) d_pend = 1'b0;
    else i_pend = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; last_d = 1'b0; d_pend = 1'b0; i_pend = 1'b0;
    exp_if_rd = 32'd0; exp_d_rd = 32'd0;
    reset_n1 = 1'b0; reset_n3 = 1'b0;
    rand_inputs();

    // Reset held for two cycles with random inputs.
    repeat (2) begin
      @(negedge clk);
      rand_inputs();
    end
    #1;
    chk("rst_ram_ce", 32'(ram_ce1), 32'd0);
    chk("rst_ram_we", 32'(ram_we1), 32'd0);
    chk("rst_ram_sel", 32'(ram_sel1), 32'd0);
    chk("rst_ram_addr", ram_addr1, 32'd0);
    chk("rst_ram_wdata", ram_wdata1, 32'd0);
    chk("rst_acks", 32'({d_ack1, if_ack1, d_ack3, if_ack3}), 32'd0);
    chk("rst_d_rdata", d_rdata1, 32'd0);
    chk("rst_if_rdata", if_rdata1, 32'd0);
    chk("rst_stall", 32'(stall1), 32'(d_req | if_req));
    chk("rst_stall3", 32'(stall3), 32'(d_req | if_req));
    rand_inputs();
    #1;
    chk("rst_stall_b", 32'(stall1), 32'(d_req | if_req));

    // Both request in the first cycle after reset: data wins the tie.
    @(negedge clk);
    reset_n1 = 1'b1;
    if_req = 1'b0; d_req = 1'b0;
    new_d(); d_we = 1'b0; new_i();
    idle_check();
    txn1();
    chk("tie_first_data", 32'(d_ack1), 32'd1);
    @(negedge clk);
    d_req = 1'b0;
    idle_check();
    txn1();
    chk("tie_then_fetch", 32'(if_ack1), 32'd1);

    // Single fetch from 0x100.
    @(negedge clk);
    if_req = 1'b1; i_pend = 1'b1; if_addr = 32'h0000_0100;
    idle_check();
    txn1();
    chk("fetch_rdata", if_rdata1, 32'h3C01_1234);

    // Single full-word data write.
    @(negedge clk);
    if_req = 1'b0;
    d_req = 1'b1; d_pend = 1'b1; d_we = 1'b1; d_sel = 4'hF;
    d_addr = 32'h0000_0080; d_wdata = 32'hDEAD_BEEF;
    idle_check();
    txn1();

    // Both continuously requesting: grants must alternate.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!d_pend) new_d();
      if (!i_pend) new_i();
      idle_check();
      txn1();
    end

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!d_pend) begin
        if ($urandom_range(1, 0) == 1) new_d();
        else d_req = 1'b0;
      end
      if (!i_pend) begin
        if ($urandom_range(1, 0) == 1) new_i();
        else if_req = 1'b0;
      end
      idle_check();
      if (d_req || if_req) txn1();
    end

    // RAM_LAT=3 instance: reset during WAIT aborts, then a clean read.
    @(negedge clk);
    d_req = 1'b0; if_req = 1'b0; reset_n1 = 1'b0; reset_n3 = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = $urandom;
    @(negedge clk);
    chk("l3_ce", 32'(ram_ce3), 32'd1);
    chk("l3_addr", ram_addr3, if_addr);
    chk("l3_sel", 32'(ram_sel3), 32'hF);
    @(negedge clk);
    chk("l3_wait_ce", 32'(ram_ce3), 32'd0);
    chk("l3_wait_ack", 32'(if_ack3), 32'd0);
    reset_n3 = 1'b0;
    @(negedge clk);
    chk("l3_abort_ce", 32'(ram_ce3), 32'd0);
    chk("l3_abort_acks", 32'({if_ack3, d_ack3}), 32'd0);
    chk("l3_abort_addr", ram_addr3, 32'd0);
    chk("l3_abort_wdata", ram_wdata3, 32'd0);
    chk("l3_abort_rdata", if_rdata3 | d_rdata3, 32'd0);
    chk("l3_abort_we_sel", 32'({ram_we3, ram_sel3}), 32'd0);
    reset_n3 = 1'b1; if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("l3_rd_ce", 32'(ram_ce3), 32'(c == 1));
      chk("l3_rd_if_ack", 32'(if_ack3), 32'd0);
      chk("l3_rd_d_ack", 32'(d_ack3), 32'(c == 5));
      chk("l3_rd_stall", 32'(stall3), 32'(c != 5));
      if (c == 1) chk("l3_rd_addr", ram_addr3, d_addr);
      if (c == 5) chk("l3_rd_data", d_rdata3, mem_f(d_addr));
    end
    @(negedge clk);
    d_req = 1'b0;
    chk("l3_ack_pulse", 32'(d_ack3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter RAM_LAT, default 1, SHALL set the RAM read latency in cycles from the ram_ce cycle to ram_rdata valid; legal values are 1..3.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 if_req  input  1  fetch request; held high until if_ack.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_rdata  output  32  fetched instruction; valid in the if_ack cycle and held until the next if_ack.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data request (MEM-stage ram_ce); held until d_ack.
REQ-009 d_we  input  1  data write enable.
REQ-010 d_sel  input  4  data byte lanes; bit3 = bits 31:24.
REQ-011 d_addr  input  32  data address.
REQ-012 d_wdata  input  32  data write value.
REQ-013 d_rdata  output  32  load data; valid in the d_ack cycle and held until the next d_ack.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 stall_req  output  1  pipeline stall request to ctrl.
REQ-016 ram_ce, ram_we  output  1 each  registered RAM chip enable and write enable.
REQ-017 ram_sel  output  4  registered RAM byte enables.
REQ-018 ram_addr, ram_wdata  output  32 each  registered RAM address and write data.
REQ-019 ram_rdata  input  32  RAM read data.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, ACCESS, WAIT and RESP.
REQ-021 IDLE with no request pending SHALL remain in IDLE.
REQ-022 IDLE with any request pending SHALL select an owner, latch that owner's attributes, and move to ACCESS.
REQ-023 When only one request is pending, that requester SHALL be the owner.
REQ-024 When both requests are pending, the requester not granted last (last_owner) SHALL be the owner, and last_owner SHALL update on every grant.
REQ-025 ACCESS SHALL last exactly one cycle with ram_ce=1.
- Data owner: ram_we=d_we, ram_sel=d_sel, ram_addr=d_addr, ram_wdata=d_wdata.
- Fetch owner: ram_we=0, ram_sel=4'b1111, ram_addr=if_addr, ram_wdata=0.
REQ-026 In all states other than ACCESS, ram_ce, ram_we and ram_sel SHALL be 0; ram_addr and ram_wdata SHALL hold their last values.
REQ-027 ACCESS for a write SHALL go to RESP.
REQ-028 ACCESS for a read SHALL go to WAIT and load a 2-bit counter with RAM_LAT.
REQ-029 WAIT SHALL decrement the counter each cycle.
REQ-030 In the WAIT cycle where the counter equals 1, ram_rdata SHALL be captured into the owner's rdata register and the FSM SHALL go to RESP.
REQ-031 RESP SHALL last one cycle, pulse the owner's ack, and return to IDLE.
REQ-032 No grant SHALL be made in RESP.
REQ-033 Latency from request to ack SHALL be RAM_LAT+2 cycles for reads and 2 cycles for writes; the next grant is possible no earlier than the cycle after RESP.
REQ-034 A requester SHALL change its request only in the cycle after its ack; request inputs are sampled only in IDLE.
REQ-035 stall_req SHALL be combinational: (d_req & ~d_ack) | (if_req & ~if_ack).
REQ-036 The non-owner's rdata and ack SHALL be unchanged during another requester's transaction.
REQ-037 Address alignment and sel legality are the requester's responsibility; the block SHALL pass them unchecked.

Reset
REQ-038 With reset_n=0 at a clock edge, the block SHALL enter IDLE; all outputs, rdata registers and the counter SHALL be 0; last_owner SHALL be fetch, so data wins the first tie.
REQ-039 Reset in any state, including WAIT or RESP, SHALL abort the transaction without an ack; ram_ce=0 from the next cycle.

Verification (RAM_LAT=1 unless stated)
REQ-040 Reset held 2 cycles with random inputs -> all outputs 0; stall_req follows inputs.
REQ-041 if_req, if_addr=0x00000100; RAM returns 0x3C011234 -> ram_ce at N+1 with sel=1111, we=0; if_ack=1 and if_rdata=0x3C011234 at N+3; stall_req low at N+3.
REQ-042 d_req, d_we=1, d_sel=1111, d_addr=0x80, d_wdata=0xDEADBEEF -> ram_ce=ram_we=1 with those values at N+1; d_ack at N+2; if_ack stays 0.
REQ-043 if_req and d_req both asserted in the first cycle after reset -> data granted first (d_ack at N+3), fetch next (ram_ce at N+5, if_ack at N+7).
REQ-044 Both requests continuously reasserted over 10 transactions -> grants strictly alternate; neither requester receives two consecutive grants.
REQ-045 RAM_LAT=3: reset_n pulsed low during WAIT -> no ack, IDLE next, ram_ce=0; a new read afterwards completes with ack 5 cycles after the request.
